// File: rtl/ioblock_pkg.sv
// ioblock_pkg -- shared constants for the I/O bank.
//   CFG_BITS      : width of one pin cell's configuration slice
//   *_LSB / *_BIT : field offsets inside a cell slice
//   TS_*          : TSMUX encodings (2'b11 behaves like TS_ON)
//   cell_cfg_t    : packed view of one cell slice, fields laid out at the offsets above
package ioblock_pkg;

   localparam int CFG_BITS   = 5;
   localparam int TSMUX_LSB  = 0;
   localparam int DORREG_BIT = 2;
   localparam int OREG_BIT   = 3;
   localparam int IREG2_BIT  = 4;

   localparam logic [1:0] TS_OFF  = 2'b00;
   localparam logic [1:0] TS_CTRL = 2'b01;
   localparam logic [1:0] TS_ON   = 2'b10;

   typedef struct packed {
      logic       ireg2;
      logic       oreg;
      logic       dorreg;
      logic [1:0] tsmux;
   } cell_cfg_t;

endpackage

// File: rtl/ioblock_cell.sv
// ioblock_cell -- one pad cell: output enable / output data path and input capture path.
//   clk_i, rst_i : bank clock and synchronous active-high reset
//   cfg_i        : active 5-bit configuration slice for this cell
//   ts_i, out_i  : fabric drive request and output data
//   pin_di_i     : value currently seen on the pad net
//   pin_oe_o     : pad output enable (pad is Z when low)
//   pin_do_o     : value to place on the pad when enabled
//   in_o         : input data returned to the fabric
module ioblock_cell
   import ioblock_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [CFG_BITS-1:0] cfg_i,
   input  logic                ts_i,
   input  logic                out_i,
   input  logic                pin_di_i,
   output logic                pin_oe_o,
   output logic                pin_do_o,
   output logic                in_o
);

   cell_cfg_t cfg;
   logic      oreg_q;
   logic      d1_q;
   logic      d2_q;

   assign cfg = cell_cfg_t'(cfg_i);

   // All data flops sample every cycle; configuration only chooses which tap is used.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         oreg_q <= 1'b0;
         d1_q   <= 1'b0;
         d2_q   <= 1'b0;
      end else begin
         oreg_q <= out_i;
         d1_q   <= pin_di_i;
         d2_q   <= d1_q;
      end
   end

   always_comb begin
      pin_oe_o = 1'b0;
      pin_do_o = cfg.oreg ? oreg_q : out_i;
      in_o     = pin_di_i;
      unique case (cfg.tsmux)
         TS_OFF:  pin_oe_o = 1'b0;
         TS_CTRL: pin_oe_o = ts_i;
         default: pin_oe_o = 1'b1;
      endcase
      if (cfg.dorreg) begin
         in_o = cfg.ireg2 ? d2_q : d1_q;
      end
   end

endmodule

// File: rtl/ioblock_bank.sv
// ioblock_bank -- bank of NPINS configurable pad cells with a serial configuration chain.
//   IOCLK, IORST : clock and synchronous active-high reset
//   PIN          : pad nets, one per cell (tristate)
//   TS, OUT      : per-pin drive request and output data from fabric
//   IN           : per-pin input data to fabric
//   CFG_EN       : shift enable; CFG_DIN enters at the top of the chain
//   CFG_LATCH    : commit request; accepted only after exactly CHAIN_LEN shifts
//   CFG_DOUT     : chain bit 0
//   CFG_ERR      : sticky, set by a rejected commit, cleared by an accepted one
module ioblock_bank
   import ioblock_pkg::*;
#(
   parameter int NPINS = 4
) (
   input  logic             IOCLK,
   input  logic             IORST,
   inout  wire  [NPINS-1:0] PIN,
   input  logic [NPINS-1:0] TS,
   input  logic [NPINS-1:0] OUT,
   output logic [NPINS-1:0] IN,
   input  logic             CFG_EN,
   input  logic             CFG_DIN,
   input  logic             CFG_LATCH,
   output logic             CFG_DOUT,
   output logic             CFG_ERR
);

   localparam int CHAIN_LEN = NPINS * CFG_BITS;
   localparam int CNT_W     = $clog2(CHAIN_LEN + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
   localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(CHAIN_LEN + 1);

   logic [CHAIN_LEN-1:0] sr_q, sr_d;
   logic [CHAIN_LEN-1:0] cfg_q, cfg_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 err_q, err_d;

   // Latch decision reads pre-edge sr_q/cnt_q, so a simultaneous shift does not
   // affect what gets committed; the counter then restarts at 1 for that shift.
   always_comb begin
      sr_d  = sr_q;
      cfg_d = cfg_q;
      cnt_d = cnt_q;
      err_d = err_q;
      if (CFG_LATCH) begin
         if (cnt_q == CNT_FULL) begin
            cfg_d = sr_q;
            err_d = 1'b0;
         end else begin
            err_d = 1'b1;
         end
         cnt_d = '0;
      end
      if (CFG_EN) begin
         sr_d = {CFG_DIN, sr_q[CHAIN_LEN-1:1]};
         if (CFG_LATCH) begin
            cnt_d = CNT_W'(1);
         end else if (cnt_q != CNT_OVER) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge IOCLK) begin
      if (IORST) begin
         sr_q  <= '0;
         cfg_q <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         sr_q  <= sr_d;
         cfg_q <= cfg_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign CFG_DOUT = sr_q[0];
   assign CFG_ERR  = err_q;

   for (genvar g = 0; g < NPINS; g++) begin : g_cell
      logic oe;
      logic dout;

      ioblock_cell u_cell (
         .clk_i    (IOCLK),
         .rst_i    (IORST),
         .cfg_i    (cfg_q[g*CFG_BITS +: CFG_BITS]),
         .ts_i     (TS[g]),
         .out_i    (OUT[g]),
         .pin_di_i (PIN[g]),
         .pin_oe_o (oe),
         .pin_do_o (dout),
         .in_o     (IN[g])
      );

      assign PIN[g] = oe ? dout : 1'bz;
   end

endmodule

// File: tb/tb_ioblock_bank.sv
module tb_ioblock_bank;

   localparam int NPINS = 4;
   localparam int CL    = NPINS * 5;

   logic             IOCLK = 1'b0;
   logic             IORST;
   logic [NPINS-1:0] TS;
   logic [NPINS-1:0] OUT;
   logic [NPINS-1:0] IN;
   logic             CFG_EN;
   logic             CFG_DIN;
   logic             CFG_LATCH;
   logic             CFG_DOUT;
   logic             CFG_ERR;
   wire  [NPINS-1:0] PIN;

   // External pad drivers; undriven pads float high through a pull-up so that
   // a released pad reads 1 and a pad driven low by the bank reads 0.
   logic [NPINS-1:0] tb_oe;
   logic [NPINS-1:0] tb_val;

   for (genvar g = 0; g < NPINS; g++) begin : g_pad
      assign PIN[g] = tb_oe[g] ? tb_val[g] : 1'bz;
      pullup pu (PIN[g]);
   end

   ioblock_bank #(.NPINS(NPINS)) dut (
      .IOCLK     (IOCLK),
      .IORST     (IORST),
      .PIN       (PIN),
      .TS        (TS),
      .OUT       (OUT),
      .IN        (IN),
      .CFG_EN    (CFG_EN),
      .CFG_DIN   (CFG_DIN),
      .CFG_LATCH (CFG_LATCH),
      .CFG_DOUT  (CFG_DOUT),
      .CFG_ERR   (CFG_ERR)
   );

   always #5 IOCLK = ~IOCLK;

   typedef struct {
      logic [NPINS-1:0] pin;
      logic [NPINS-1:0] in;
      logic             dout;
      logic             err;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference model: per-pin decoded fields, chain as a bit queue (element 0 = chain bit 0),
   // shift count, sticky error, and short histories of OUT and pad values.
   int  m_ts[NPINS];
   bit  m_dor[NPINS];
   bit  m_oreg[NPINS];
   bit  m_ir2[NPINS];
   bit  m_sr[$];
   int  m_cnt;
   bit  m_err;
   bit  m_out_prev[NPINS];
   bit  m_pin_h1[NPINS];
   bit  m_pin_h2[NPINS];
   bit  m_pin_now[NPINS];
   bit  m_known;

   function automatic void model_reset();
      m_sr.delete();
      for (int i = 0; i < CL; i++) m_sr.push_back(1'b0);
      for (int i = 0; i < NPINS; i++) begin
         m_ts[i] = 0; m_dor[i] = 0; m_oreg[i] = 0; m_ir2[i] = 0;
         m_out_prev[i] = 0; m_pin_h1[i] = 0; m_pin_h2[i] = 0;
      end
      m_cnt = 0;
      m_err = 0;
   endfunction

   task automatic cmp(input string name, input logic [NPINS-1:0] act, input logic [NPINS-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every cycle the bank presents pad/IN/chain outputs; compare at the falling edge.
   always @(negedge IOCLK) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         cmp("PIN",      PIN,                     e.pin);
         cmp("IN",       IN,                      e.in);
         cmp("CFG_DOUT", NPINS'(CFG_DOUT),        NPINS'(e.dout));
         cmp("CFG_ERR",  NPINS'(CFG_ERR),         NPINS'(e.err));
      end
   end

   // One clock cycle: apply inputs, predict outputs, advance the model at the edge.
   task automatic step(input bit rst, input bit en, input bit din, input bit lat);
      exp_t e;
      bit   drv;
      IORST     = rst;
      CFG_EN    = en;
      CFG_DIN   = din;
      CFG_LATCH = lat;
      TS        = NPINS'($urandom);
      OUT       = NPINS'($urandom);
      for (int i = 0; i < NPINS; i++) begin
         if (m_ts[i] == 0)      drv = 1'b0;
         else if (m_ts[i] == 1) drv = TS[i];
         else                   drv = 1'b1;
         if (drv) begin
            tb_oe[i]     = 1'b0;
            tb_val[i]    = 1'($urandom);
            m_pin_now[i] = m_oreg[i] ? m_out_prev[i] : OUT[i];
         end else begin
            tb_oe[i]     = m_known ? 1'($urandom) : 1'b0;
            tb_val[i]    = 1'($urandom);
            m_pin_now[i] = tb_oe[i] ? tb_val[i] : 1'b1;
         end
         e.pin[i] = m_pin_now[i];
         e.in[i]  = !m_dor[i] ? m_pin_now[i] : (m_ir2[i] ? m_pin_h2[i] : m_pin_h1[i]);
      end
      e.dout = m_sr[0];
      e.err  = m_err;
      if (m_known) q.push_back(e);
      @(posedge IOCLK);
      if (rst) begin
         model_reset();
         m_known = 1'b1;
      end else begin
         for (int i = 0; i < NPINS; i++) begin
            m_out_prev[i] = OUT[i];
            m_pin_h2[i]   = m_pin_h1[i];
            m_pin_h1[i]   = m_pin_now[i];
         end
         if (lat) begin
            if (m_cnt == CL) begin
               for (int i = 0; i < NPINS; i++) begin
                  m_ts[i]   = int'(m_sr[5*i]) + 2 * int'(m_sr[5*i+1]);
                  m_dor[i]  = m_sr[5*i+2];
                  m_oreg[i] = m_sr[5*i+3];
                  m_ir2[i]  = m_sr[5*i+4];
               end
               m_err = 1'b0;
            end else begin
               m_err = 1'b1;
            end
         end
         if (en) begin
            void'(m_sr.pop_front());
            m_sr.push_back(din);
         end
         if (lat)                      m_cnt = en ? 1 : 0;
         else if (en && m_cnt < CL + 1) m_cnt++;
      end
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 1'($urandom), 1'b0);
   endtask

   task automatic shift_only(input logic [31:0] bits, input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b1, bits[k], 1'b0);
   endtask

   task automatic load(input logic [31:0] bits, input int n);
      shift_only(bits, n);
      step(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   // Pin0: TSMUX=10 OREG=1; pin1: TSMUX=01; pin2: DORREG=1 IREG2=1, Z; pin3: off.
   localparam logic [31:0] CFG_A = {12'h000, 5'b00000, 5'b10100, 5'b00001, 5'b01010};

   initial begin
      model_reset();
      m_known   = 1'b0;
      tb_oe     = '0;
      tb_val    = '0;
      IORST     = 1'b1;
      CFG_EN    = 1'b0;
      CFG_DIN   = 1'b0;
      CFG_LATCH = 1'b0;
      TS        = '0;
      OUT       = '0;
      #1;

      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      idle(8);

      load(CFG_A, 20);
      idle(40);

      load($urandom, 19);
      idle(5);
      load($urandom, 21);
      idle(5);
      load(CFG_A, 20);
      idle(10);

      shift_only($urandom, 10);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      load(CFG_A ^ 32'h0000_8421, 20);
      shift_only($urandom, 25);
      idle(5);

      shift_only(CFG_A, 20);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      idle(3);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      idle(3);

      repeat (400) begin
         step(1'($urandom_range(0, 149) == 0), 1'($urandom), 1'($urandom),
              1'($urandom_range(0, 22) == 0));
      end

      repeat (8) begin
         load($urandom, 20);
         idle(40);
      end

      @(negedge IOCLK);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ioblock_bank.md
IOBLOCK_BANK -- requirements
Module: ioblock_bank

Interface
REQ-001 SHALL have parameter NPINS, default 4, number of independent pin cells (1..32).
REQ-002 SHALL have derived constant CHAIN_LEN = NPINS*5, config chain length in bits.
REQ-003 SHALL have port IOCLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port IORST  input  1  synchronous active-high reset.
REQ-005 SHALL have port PIN  inout  NPINS  pad nets, one per cell.
REQ-006 SHALL have port TS  input  NPINS  per-pin drive request, used when TSMUX=01.
REQ-007 SHALL have port OUT  input  NPINS  per-pin output data.
REQ-008 SHALL have port IN  output  NPINS  per-pin input data to fabric.
REQ-009 SHALL have port CFG_EN  input  1  shift-enable for config chain.
REQ-010 SHALL have port CFG_DIN  input  1  serial config data in.
REQ-011 SHALL have port CFG_LATCH  input  1  one-cycle request to commit shifted config.
REQ-012 SHALL have port CFG_DOUT  output  1  serial config data out (chain bit 0).
REQ-013 SHALL have port CFG_ERR  output  1  sticky flag: latch rejected for wrong shift count.

Function
REQ-014 SHALL hold per cell i a 5-bit active config at chain bits [5i+4:5i]: [1:0] TSMUX, [2] DORREG, [3] OREG, [4] IREG2.
REQ-015 TSMUX SHALL select: 00 PIN=Z; 01 drive when TS[i]=1, Z when TS[i]=0; 10/11 always drive.
REQ-016 Driven value SHALL be OUT[i] combinationally when OREG=0, and OUT[i] registered one IOCLK cycle when OREG=1; TS path always combinational.
REQ-017 IN[i] SHALL be PIN[i] combinationally when DORREG=0; D1 (PIN sampled each edge, 1-cycle latency) when DORREG=1, IREG2=0; D2 (second flop after D1, 2-cycle latency) when DORREG=1, IREG2=1.
REQ-018 D1, D2 and the output register SHALL sample every cycle regardless of config.
REQ-019 With CFG_EN=1, shift register SR SHALL update SR <= {CFG_DIN, SR[CHAIN_LEN-1:1]}; CFG_DOUT = SR[0] at all times.
REQ-020 Shift counter SHALL increment per CFG_EN cycle, saturating at CHAIN_LEN+1 (overshift marker).
REQ-021 CFG_LATCH with counter == CHAIN_LEN SHALL copy SR to active config on that edge and clear CFG_ERR; pin behaviour changes from the following cycle.
REQ-022 CFG_LATCH with counter != CHAIN_LEN SHALL leave active config unchanged and set CFG_ERR.
REQ-023 Any CFG_LATCH SHALL reset the counter to 0; SR contents SHALL be kept.
REQ-024 CFG_LATCH and CFG_EN in the same cycle: latch decision and copy use pre-edge SR and counter; the shift still occurs; counter ends at 1.
REQ-025 Shifting SHALL never disturb active config or pin behaviour.

Reset
REQ-026 IORST SHALL clear SR, active config (all pins Z, IN combinational), D1, D2, output registers, counter, and CFG_ERR to 0 on the next edge.
REQ-027 IORST SHALL take priority over CFG_EN and CFG_LATCH; reset mid-shift discards the partial chain.

Structure
REQ-028 Shared package ioblock_pkg SHALL hold CFG_BITS=5, field bit offsets, and TSMUX encodings (TS_OFF, TS_CTRL, TS_ON).
REQ-029 A per-pin sub-module ioblock_cell SHALL implement REQ-015..018, instantiated NPINS times; chain, counter and latch logic SHALL live in ioblock_bank.

Verification
REQ-030 After reset, NPINS=4: all PIN=Z, IN follows externally driven PIN same cycle, CFG_ERR=0, CFG_DOUT=0.
REQ-031 Shift 20 bits configuring pin0 TSMUX=10 OREG=1, then LATCH: PIN[0] follows OUT[0] one cycle late, other pins Z, CFG_ERR=0.
REQ-032 Pin1 TSMUX=01: TS[1]=0 -> PIN[1]=Z; TS[1]=1, OUT[1]=1 -> PIN[1]=1 same cycle.
REQ-033 Pin2 DORREG=1 IREG2=1, pulse external PIN[2] high one cycle: IN[2] high exactly 2 cycles later for one cycle.
REQ-034 Shift 19 bits then LATCH -> CFG_ERR=1, config unchanged; shift 21 bits then LATCH -> CFG_ERR stays 1; correct 20-bit load -> CFG_ERR=0.
REQ-035 Assert IORST after 10 shift cycles, then 20 shifts plus LATCH: accepted, CFG_DOUT replays loaded bits in order on further shifts.
